// File: rtl/disk_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// disk_pkg : shared types and helpers for the floppy track loader
// Revision : 1.0
// ------------------------------------------------------------------
package disk_pkg;

  localparam int SECTOR_BYTES = 512;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    LOAD  = 2'd2
  } state_t;

  typedef enum logic {
    REQ  = 1'b0,
    XFER = 1'b1
  } phase_t;

  function automatic logic [31:0] calc_lba(input logic [31:0] spt,
                                           input logic [31:0] trk,
                                           input logic [31:0] sec);
    return spt * trk + sec;
  endfunction

endpackage
`default_nettype wire

// File: rtl/disk_track_loader_if.sv
`default_nettype none
// ------------------------------------------------------------------
// disk_track_loader_if : SD sector handshake and track RAM select bus
// Revision : 1.0
// ------------------------------------------------------------------
interface disk_track_loader_if #(
  parameter int DRIVES = 2,
  parameter int SEC_W  = 4
);
  logic [DRIVES-1:0] sd_rd;
  logic [DRIVES-1:0] sd_wr;
  logic [DRIVES-1:0] sd_ack;
  logic [31:0]       sd_lba;
  logic [1:0]        buf_drive;
  logic [SEC_W-1:0]  buf_sec;

  modport master (output sd_rd, sd_wr, sd_lba, buf_drive, buf_sec, input sd_ack);
  modport slave  (input sd_rd, sd_wr, sd_lba, buf_drive, buf_sec, output sd_ack);
endinterface
`default_nettype wire

// File: rtl/sd_sector_hs.sv
`default_nettype none
// ------------------------------------------------------------------
// sd_sector_hs : ack edge detector for one sector handshake channel
// Revision : 1.0
// ------------------------------------------------------------------
module sd_sector_hs (
  input  logic clk_sys,
  input  logic reset,
  input  logic ack,
  output logic rise,
  output logic fall
);
  logic ack_q;

  always_ff @(posedge clk_sys) begin
    if (reset) ack_q <= 1'b0;
    else       ack_q <= ack;
  end

  assign rise = ack & ~ack_q;
  assign fall = ~ack & ack_q;
endmodule
`default_nettype wire

// File: rtl/disk_track_loader.sv
`default_nettype none
// ------------------------------------------------------------------
// disk_track_loader : multi-drive track buffer with dirty-sector writeback
// Revision : 1.0
// ------------------------------------------------------------------
module disk_track_loader
  import disk_pkg::*;
#(
  parameter int DRIVES         = 2,
  parameter int SECS_PER_TRACK = 13,
  parameter int TRACK_W        = 6,
  parameter int SEC_W          = 4
) (
  input  logic                      clk_sys,
  input  logic                      reset,
  input  logic [DRIVES*TRACK_W-1:0] track,
  input  logic [DRIVES-1:0]         img_mounted,
  input  logic [DRIVES-1:0]         img_present,
  input  logic [DRIVES-1:0]         dirty_we,
  input  logic [SEC_W-1:0]          dirty_sec,
  disk_track_loader_if.master       sd,
  output logic                      cpu_wait,
  output logic [DRIVES-1:0]         busy
);
  localparam int NSEC = 2**SEC_W;
  localparam logic [31:0] SPT = 32'(SECS_PER_TRACK);

  logic [TRACK_W-1:0] cur_track [DRIVES];
  logic [NSEC-1:0]    dirty     [DRIVES];
  logic [DRIVES-1:0]  mount_pend;

  state_t             state_q, state_n;
  phase_t             phase_q, phase_n;
  logic [1:0]         drv_q, drv_n, tgt, fd;
  logic [SEC_W-1:0]   sec_q, sec_n;
  logic [TRACK_W-1:0] base_q, base_n;
  logic               rd_q, rd_n, wr_q, wr_n, wait_q, wait_n;
  logic [31:0]        lba_q, lba_n;
  logic               upd_track, clr_mount, clr_dirty, clr_bit;

  logic               found, mnt_fd, pres_fd, ack_sel, ack_rise, ack_fall;
  logic [TRACK_W-1:0] trk_fd, cur_fd, trk_cur;
  logic [NSEC-1:0]    dirty_fd, dirty_cur;

  function automatic logic [SEC_W-1:0] lowest(input logic [NSEC-1:0] v);
    logic [SEC_W-1:0] r;
    r = '0;
    for (int k = NSEC-1; k >= 0; k--) if (v[k]) r = SEC_W'(k);
    return r;
  endfunction

  sd_sector_hs u_hs (
    .clk_sys (clk_sys),
    .reset   (reset),
    .ack     (ack_sel),
    .rise    (ack_rise),
    .fall    (ack_fall)
  );

  // fd: lowest drive needing service; *_cur: views of the drive owning the transfer
  always_comb begin
    found = 1'b0;
    fd    = '0;
    for (int i = DRIVES-1; i >= 0; i--) begin
      if ((cur_track[i] != track[i*TRACK_W +: TRACK_W]) || mount_pend[i]) begin
        found = 1'b1;
        fd    = 2'(i);
      end
    end
    trk_fd = '0; cur_fd = '0; dirty_fd = '0; mnt_fd = 1'b0; pres_fd = 1'b0;
    ack_sel = 1'b0; trk_cur = '0; dirty_cur = '0;
    for (int i = 0; i < DRIVES; i++) begin
      if (fd == 2'(i)) begin
        trk_fd   = track[i*TRACK_W +: TRACK_W];
        cur_fd   = cur_track[i];
        dirty_fd = dirty[i];
        mnt_fd   = mount_pend[i];
        pres_fd  = img_present[i];
      end
      if (drv_q == 2'(i)) begin
        ack_sel   = sd.sd_ack[i];
        trk_cur   = track[i*TRACK_W +: TRACK_W];
        dirty_cur = dirty[i];
      end
    end
  end

  always_comb begin
    state_n = state_q; phase_n = phase_q; drv_n = drv_q; sec_n = sec_q;
    base_n = base_q; rd_n = rd_q; wr_n = wr_q; wait_n = wait_q; lba_n = lba_q;
    tgt = drv_q; upd_track = 1'b0; clr_mount = 1'b0; clr_dirty = 1'b0; clr_bit = 1'b0;
    case (state_q)
      IDLE: begin
        tgt = fd;
        if (found) begin
          if (!pres_fd) begin
            upd_track = 1'b1; clr_mount = 1'b1; clr_dirty = 1'b1;
          end else begin
            drv_n = fd; wait_n = 1'b1; phase_n = REQ;
            if (!mnt_fd && (dirty_fd != '0)) begin
              state_n = FLUSH; base_n = cur_fd; sec_n = lowest(dirty_fd); wr_n = 1'b1;
              lba_n = calc_lba(SPT, 32'(cur_fd), 32'(lowest(dirty_fd)));
            end else begin
              upd_track = 1'b1; clr_mount = 1'b1; clr_dirty = 1'b1;
              state_n = LOAD; base_n = trk_fd; sec_n = '0; rd_n = 1'b1;
              lba_n = calc_lba(SPT, 32'(trk_fd), 32'd0);
            end
          end
        end
      end
      FLUSH: begin
        if (phase_q == REQ) begin
          if (ack_rise) begin
            wr_n = 1'b0; phase_n = XFER; clr_bit = 1'b1;
          end
        end else if (ack_fall) begin
          phase_n = REQ;
          if (dirty_cur != '0) begin
            sec_n = lowest(dirty_cur); wr_n = 1'b1;
            lba_n = calc_lba(SPT, 32'(base_q), 32'(lowest(dirty_cur)));
          end else begin
            state_n = LOAD; base_n = trk_cur; sec_n = '0; rd_n = 1'b1;
            upd_track = 1'b1; clr_mount = 1'b1;
            lba_n = calc_lba(SPT, 32'(trk_cur), 32'd0);
          end
        end
      end
      LOAD: begin
        if (phase_q == REQ) begin
          if (ack_rise) begin
            rd_n = 1'b0; phase_n = XFER;
          end
        end else if (ack_fall) begin
          if (sec_q == SEC_W'(SECS_PER_TRACK-1)) begin
            state_n = IDLE; wait_n = 1'b0;
          end else begin
            sec_n = sec_q + 1'b1; rd_n = 1'b1; phase_n = REQ;
            lba_n = calc_lba(SPT, 32'(base_q), 32'(sec_q + 1'b1));
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= IDLE; phase_q <= REQ; drv_q <= '0; sec_q <= '0; base_q <= '0;
      rd_q <= 1'b0; wr_q <= 1'b0; wait_q <= 1'b0; lba_q <= '0;
    end else begin
      state_q <= state_n; phase_q <= phase_n; drv_q <= drv_n; sec_q <= sec_n;
      base_q <= base_n; rd_q <= rd_n; wr_q <= wr_n; wait_q <= wait_n; lba_q <= lba_n;
    end
  end

  // Later assignments win: new mounts and core writes override same-cycle clears
  always_ff @(posedge clk_sys) begin
    for (int i = 0; i < DRIVES; i++) begin
      if (reset) begin
        cur_track[i]  <= '0;
        dirty[i]      <= '0;
        mount_pend[i] <= 1'b0;
      end else begin
        if (upd_track && (tgt == 2'(i))) cur_track[i] <= track[i*TRACK_W +: TRACK_W];
        if (clr_mount && (tgt == 2'(i))) mount_pend[i] <= 1'b0;
        if (img_mounted[i])              mount_pend[i] <= 1'b1;
        if (clr_dirty && (tgt == 2'(i))) dirty[i] <= '0;
        if (clr_bit && (drv_q == 2'(i))) dirty[i][sec_q] <= 1'b0;
        if (dirty_we[i])                 dirty[i][dirty_sec] <= 1'b1;
      end
    end
  end

  always_comb begin
    sd.sd_rd = '0;
    sd.sd_wr = '0;
    busy     = '0;
    for (int i = 0; i < DRIVES; i++) begin
      sd.sd_rd[i] = rd_q   && (drv_q == 2'(i));
      sd.sd_wr[i] = wr_q   && (drv_q == 2'(i));
      busy[i]     = wait_q && (drv_q == 2'(i));
    end
  end

  assign sd.sd_lba    = lba_q;
  assign sd.buf_drive = drv_q;
  assign sd.buf_sec   = sec_q;
  assign cpu_wait     = wait_q;
endmodule
`default_nettype wire

// File: doc/disk_track_loader.md
Name: disk_track_loader

Overview:
- Parametrised multi-drive track buffer controller for the Apple II sim top; successor to the single-drive, read-only floppy track loader.
- Per drive: detects a track change or image mount, writes back dirty sectors of the old track, then streams the new track into the shared track RAM over the sd_rd/sd_wr/sd_ack sector handshake.
- Stalls the CPU while a transfer is in flight.

Parameters:
DRIVES, 2, number of floppy channels (1..4)
SECS_PER_TRACK, 13, 512-byte sectors per track; LBA base = SECS_PER_TRACK*track
TRACK_W, 6, track number width
SEC_W, 4, sector index width (2**SEC_W >= SECS_PER_TRACK)

Ports:
clk_sys  in  1  system clock
reset  in  1  synchronous, active-high reset
track  in  DRIVES*TRACK_W  current head track per drive, drive d at [d*TRACK_W +: TRACK_W]
img_mounted  in  DRIVES  one-cycle mount strobe per drive
img_present  in  DRIVES  image size nonzero, level
dirty_we  in  DRIVES  core wrote a byte of the buffered track (pulse)
dirty_sec  in  SEC_W  sector index of that write
sd_ack  in  DRIVES  SD block handshake acknowledge
sd_rd  out  DRIVES  sector read request
sd_wr  out  DRIVES  sector write request
sd_lba  out  32  sector LBA of the active request
buf_drive  out  2  drive owning the current transfer, for track RAM bank select
buf_sec  out  SEC_W  sector slot of the transfer, for track RAM address high bits
cpu_wait  out  1  CPU stall
busy  out  DRIVES  per-drive transfer in progress

Behaviour:
Reset values:
- sd_rd=0, sd_wr=0, sd_lba=0, buf_drive=0, buf_sec=0, cpu_wait=0, busy=0.
- cur_track[*]=0, dirty[*]=0, mount_pend[*]=0.
- FSM in IDLE.

Latches (every cycle, including while busy):
- mount_pend[d] |= img_mounted[d].
- dirty[d][dirty_sec] set on dirty_we[d].

FSM states: IDLE, FLUSH, LOAD. Each transfer state has sub-phases REQ (waiting for ack rise) and XFER (waiting for ack fall). The ack edge is detected from a registered copy of sd_ack[d].

IDLE:
- Select the lowest-index drive d with cur_track[d]!=track[d] or mount_pend[d].
- If img_present[d]=0: cur_track[d]<=track[d], clear mount_pend[d] and dirty[d], stay IDLE, no request.
- Else if mount_pend[d]=0 and dirty[d]!=0: go to FLUSH with base = cur_track[d]. Dirty data of a newly mounted image is discarded.
- Else: clear mount_pend[d] and dirty[d], cur_track[d]<=track[d], go to LOAD with base = track[d], buf_sec=0.
- On leaving IDLE, capture d into buf_drive; cpu_wait<=1 and busy[d]<=1 in the same cycle.

FLUSH:
- buf_sec = lowest set dirty bit.
- REQ: sd_wr[d]=1, sd_lba = SECS_PER_TRACK*base + buf_sec.
- Ack rise: sd_wr[d]<=0; clear dirty[d][buf_sec] unless dirty_we hits the same sector that cycle (write wins).
- Ack fall: pick the next dirty sector. If none remain, go to LOAD: base = track[d] sampled now, cur_track[d]<=track[d], clear mount_pend[d], buf_sec=0.

LOAD:
- REQ: sd_rd[d]=1, sd_lba = SECS_PER_TRACK*base + buf_sec.
- Ack rise: sd_rd[d]<=0.
- Ack fall: if buf_sec==SECS_PER_TRACK-1, go to IDLE, clear cpu_wait and busy[d]; else buf_sec+1 and re-enter REQ one cycle later.

Rules:
- Only one sd_rd/sd_wr bit is ever high, and never both.
- LBA arithmetic is 32-bit unsigned, with no wrap for legal tracks.
- A track change during LOAD is not aborted; it is caught on return to IDLE and reloads.
- Mount strobe during a transfer: latched, serviced afterwards.
- Reset mid-transfer: all requests drop the next cycle and dirty state is lost.
- Ack must not rise before its request; a spurious ack in IDLE is ignored.
- Typical track load latency = 13 handshakes plus 1 idle cycle.

Decomposition:
- Package disk_pkg: SECTOR_BYTES=512, the state enum (IDLE, FLUSH, LOAD), and the phase enum (REQ, XFER).
- Sub-module sd_sector_hs: one-channel request/ack edge handshaker emitting rise/fall pulses. Instantiated once; it operates on the selected drive's ack.

Test Plan:
- Drive0 track 0→5 from reset with img_present=1 → 13 sd_rd[0] requests, LBA 65..77, buf_sec 0..12; cpu_wait high from the cycle after the change until the cycle after the 13th ack fall.
- dirty_we[0] with sectors 3 and 7 while on track 5, then track→6 → sd_wr[0] at LBA 68 then 72, then sd_rd[0] at LBA 78..90; dirty cleared.
- img_mounted[1] and drive0 track change in the same cycle → drive0 serviced first, then drive1 loads track track[1] with no writeback.
- Mount on drive0 with dirty sectors pending → no sd_wr; reload from LBA 13*track.
- img_present[1]=0 with a track change → no request, cpu_wait stays 0, cur_track updates.
- Reset asserted at the 4th LOAD request → sd_rd=0, cpu_wait=0 the next cycle; after release, a new track change loads cleanly from sector 0.
